sad_row_sequencer: RTL

Control end of the horizontal sub-pel SAD datapath: fetches an 8x8 filter block and an 8x8 reference block row by row from a 64-bit pixel memory, presents each row pair to the combinational SAD unit with `input_ready`, and sums the five returned per-row SADs over all eight rows. At block end it reports the winning horizontal position and its block SAD. It sits between the frame-buffer read port and the SAD datapath, and the motion-estimation controller drives it.

---
 rtl/sad_row_sequencer.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/sad_row_sequencer.sv
// Row sequencer for the horizontal sub-pel SAD datapath: fetches filter/reference rows,
// accumulates five per-row SADs and reports the best position. Optional macro: SAD_EARLY_TERM_EN.
module sad_row_sequencer #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] filt_base,
    input  logic [ADDR_W-1:0] ref_base,
    input  logic [15:0]       sad_limit,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [63:0]       rd_data,
    output logic [63:0]       filter_pix,
    output logic [63:0]       ref_pix,
    output logic              input_ready,
    input  logic [64:0]       sad,
    output logic              busy,
    output logic              done,
    output logic [2:0]        best_idx,
    output logic [15:0]       best_sad,
    output logic              early_term
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_FILT,
        S_RD_REF,
        S_LATCH,
        S_ISSUE,
        S_DONE
    } state_t;

    state_t            state_reg, state_next;
    logic [2:0]        row_reg;
    logic [ADDR_W-1:0] filt_base_reg, ref_base_reg;
    logic [63:0]       filter_pix_reg, ref_pix_reg;
    logic [15:0]       acc_reg [5];
    logic [15:0]       acc_upd [5];
    logic [2:0]        best_idx_reg;
    logic [15:0]       best_sad_reg;
    logic              early_term_reg;
    logic [15:0]       min_val;
    logic [2:0]        min_idx;
    logic              stop_early;
    logic              start_accept;

    assign start_accept = (state_reg == S_IDLE) && start;

    // Five accumulators; 8 rows of 13-bit fields fit in 16 bits, so no saturation.
    for (genvar gi = 0; gi < 5; gi++) begin : g_acc
        assign acc_upd[gi] = acc_reg[gi] + 16'(sad[13*gi +: 13]);

        always_ff @(posedge clk) begin
            if (rst || start_accept) begin
                acc_reg[gi] <= '0;
            end else if (state_reg == S_ISSUE) begin
                acc_reg[gi] <= acc_upd[gi];
            end
        end
    end

    // Minimum of the post-update sums; full-pel (field 2) wins any tie it is part of.
    always_comb begin
        min_val = acc_upd[0];
        min_idx = 3'd0;
        for (int k = 1; k < 5; k++) begin
            if (acc_upd[k] < min_val) begin
                min_val = acc_upd[k];
                min_idx = 3'(k);
            end
        end
        if (acc_upd[2] == min_val) begin
            min_idx = 3'd2;
        end
    end

`ifdef SAD_EARLY_TERM_EN
    assign stop_early = (min_val > sad_limit);
`else
    logic unused_sad_limit;
    assign unused_sad_limit = ^sad_limit;
    assign stop_early       = 1'b0;
`endif

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:    if (start) state_next = S_RD_FILT;
            S_RD_FILT: state_next = S_RD_REF;
            S_RD_REF:  state_next = S_LATCH;
            S_LATCH:   state_next = S_ISSUE;
            S_ISSUE:   state_next = (row_reg == 3'd7 || stop_early) ? S_DONE : S_RD_FILT;
            S_DONE:    state_next = S_IDLE;
            default:   state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= S_IDLE;
            row_reg        <= '0;
            filt_base_reg  <= '0;
            ref_base_reg   <= '0;
            filter_pix_reg <= '0;
            ref_pix_reg    <= '0;
            best_idx_reg   <= '0;
            best_sad_reg   <= '0;
            early_term_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        row_reg        <= '0;
                        filt_base_reg  <= filt_base;
                        ref_base_reg   <= ref_base;
                        best_idx_reg   <= '0;
                        best_sad_reg   <= '0;
                        early_term_reg <= 1'b0;
                    end
                end
                S_RD_REF: filter_pix_reg <= rd_data;
                S_LATCH:  ref_pix_reg    <= rd_data;
                S_ISSUE: begin
                    row_reg <= row_reg + 3'd1;
                    if (state_next == S_DONE) begin
                        best_idx_reg   <= min_idx;
                        best_sad_reg   <= min_val;
                        early_term_reg <= stop_early;
                    end
                end
                default: ;
            endcase
        end
    end

    // Address is forced to zero outside the two read states so idle outputs are all 0.
    always_comb begin
        rd_en   = 1'b0;
        rd_addr = '0;
        if (state_reg == S_RD_FILT) begin
            rd_en   = 1'b1;
            rd_addr = filt_base_reg + ADDR_W'(row_reg);
        end else if (state_reg == S_RD_REF) begin
            rd_en   = 1'b1;
            rd_addr = ref_base_reg + ADDR_W'(row_reg);
        end
    end

    assign filter_pix  = filter_pix_reg;
    assign ref_pix     = ref_pix_reg;
    assign input_ready = (state_reg == S_ISSUE);
    assign busy        = (state_reg == S_RD_FILT) || (state_reg == S_RD_REF) ||
                         (state_reg == S_LATCH)   || (state_reg == S_ISSUE);
    assign done        = (state_reg == S_DONE);
    assign best_idx    = best_idx_reg;
    assign best_sad    = best_sad_reg;
    assign early_term  = early_term_reg;

endmodule
